// File: rtl/tail_light_pkg.sv
// Shared definitions for the tail-light sequencer: state encoding,
// lamp pattern constants and the right-side lamp ordering helper.
package tail_light_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE  = 4'd0;
    localparam state_t S_L1    = 4'd1;
    localparam state_t S_L2    = 4'd2;
    localparam state_t S_L3    = 4'd3;
    localparam state_t S_LOFF  = 4'd4;
    localparam state_t S_R1    = 4'd5;
    localparam state_t S_R2    = 4'd6;
    localparam state_t S_R3    = 4'd7;
    localparam state_t S_ROFF  = 4'd8;
    localparam state_t S_H_ON  = 4'd9;
    localparam state_t S_H_OFF = 4'd10;

    // Patterns are {C, B, A}: bit 0 is the innermost lamp.
    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_1   = 3'b001;
    localparam logic [2:0] PAT_2   = 3'b011;
    localparam logic [2:0] PAT_3   = 3'b111;

    // Right lamps are packed {RA, RB, RC}, so the innermost lamp moves to bit 2.
    function automatic logic [2:0] right_order(input logic [2:0] pat);
        return {pat[0], pat[1], pat[2]};
    endfunction

endpackage

// File: rtl/tail_light_sequencer_if.sv
// Request inputs and lamp/status outputs of the tail-light sequencer.
interface tail_light_sequencer_if;
    logic l;
    logic r;
    logic haz;
    logic brake;
    logic LA;
    logic LB;
    logic LC;
    logic RA;
    logic RB;
    logic RC;
    logic busy;
    logic tick;

    modport master (
        output l, r, haz, brake,
        input  LA, LB, LC, RA, RB, RC, busy, tick
    );

    modport slave (
        input  l, r, haz, brake,
        output LA, LB, LC, RA, RB, RC, busy, tick
    );
endinterface

// File: rtl/tail_light_sequencer_tick_prescaler.sv
// Step prescaler: counts 0..DIV-1, strobes tick on the last count,
// and can be cleared so a new step always lasts a full DIV cycles.
module tick_prescaler #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear request, wrap at the terminal count, else increment.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);
endmodule

// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: arbitrates turn/hazard/brake requests and drives
// the six rear lamps. Lamps are registered from the next state so they
// change on the same edge as the state.
//
//   state  | meaning
//   IDLE   | no sweep; lamps show brake only
//   L1..L3 | left sweep, 1..3 lamps lit
//   LOFF   | left sweep dark step; decision taken when it ends
//   R1..R3 | right sweep, 1..3 lamps lit
//   ROFF   | right sweep dark step; decision taken when it ends
//   H_ON   | hazard, all six lamps lit
//   H_OFF  | hazard, all lamps dark
module tail_light_sequencer
    import tail_light_pkg::*;
#(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    tail_light_sequencer_if.slave bus
);
    state_t     state_q;
    state_t     state_d;
    logic [5:0] lamps_q;
    logic [5:0] lamps_d;
    logic       busy_q;
    logic       tick;
    logic       clr;
    logic       req_h;
    logic       req_l;
    logic       req_r;
    logic       in_sweep;

    assign req_h = bus.haz | (bus.l & bus.r);
    assign req_l = bus.l & ~bus.r & ~bus.haz;
    assign req_r = bus.r & ~bus.l & ~bus.haz;

    assign in_sweep = (state_q >= S_L1) && (state_q <= S_ROFF);

    function automatic state_t decide(input logic h, input logic lft, input logic rgt);
        if (h)   return S_H_ON;
        if (lft) return S_L1;
        if (rgt) return S_R1;
        return S_IDLE;
    endfunction

    function automatic logic [2:0] step_pat(input state_t s);
        case (s)
            S_L1, S_R1: return PAT_1;
            S_L2, S_R2: return PAT_2;
            S_L3, S_R3: return PAT_3;
            default:    return PAT_OFF;
        endcase
    endfunction

    // The prescaler restarts whenever a fresh sequence begins (from IDLE or preemption).
    assign clr = (state_q == S_IDLE) || (in_sweep && req_h);

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // Next-state: hazard preempts sweeps; otherwise steps advance only on tick.
    always_comb begin
        state_d = state_q;
        if (in_sweep && req_h) begin
            state_d = S_H_ON;
        end else begin
            case (state_q)
                S_IDLE:  state_d = decide(req_h, req_l, req_r);
                S_L1:    if (tick) state_d = S_L2;
                S_L2:    if (tick) state_d = S_L3;
                S_L3:    if (tick) state_d = S_LOFF;
                S_R1:    if (tick) state_d = S_R2;
                S_R2:    if (tick) state_d = S_R3;
                S_R3:    if (tick) state_d = S_ROFF;
                S_H_ON:  if (tick) state_d = S_H_OFF;
                S_LOFF, S_ROFF, S_H_OFF: begin
                    if (tick) state_d = decide(req_h, req_l, req_r);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Lamp image for the next state: {LC, LB, LA, RA, RB, RC}.
    always_comb begin
        lamps_d = '0;
        case (state_d)
            S_L1, S_L2, S_L3, S_LOFF: begin
                lamps_d[5:3] = step_pat(state_d);
                lamps_d[2:0] = bus.brake ? PAT_3 : PAT_OFF;
            end
            S_R1, S_R2, S_R3, S_ROFF: begin
                lamps_d[5:3] = bus.brake ? PAT_3 : PAT_OFF;
                lamps_d[2:0] = right_order(step_pat(state_d));
            end
            S_H_ON:  lamps_d = '1;
            S_H_OFF: lamps_d = '0;
            default: lamps_d = bus.brake ? '1 : '0;
        endcase
    end

    // State, lamp and busy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lamps_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lamps_q <= lamps_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign bus.LC   = lamps_q[5];
    assign bus.LB   = lamps_q[4];
    assign bus.LA   = lamps_q[3];
    assign bus.RA   = lamps_q[2];
    assign bus.RB   = lamps_q[1];
    assign bus.RC   = lamps_q[0];
    assign bus.busy = busy_q;
    assign bus.tick = tick;
endmodule

// File: doc/tail_light_sequencer.md
# tail_light_sequencer

Sequences the six rear turn lamps (LA/LB/LC left, RA/RB/RC right) from driver requests: left turn, right turn, hazard and brake. An internal prescaler sets the step period. The block arbitrates between competing requests, so that a left/right direction change never cuts a running sweep and hazard always preempts. It sits between the switch/debounce inputs and the lamp drivers and supersedes the free-running per-side pattern logic.

## Interface
- DIV, default 50_000_000: step period in clk cycles; legal range ≥ 2.
- CNT_W, default $clog2(DIV): prescaler counter width; derived, not overridden.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- l  in  1  left-turn request, level, synchronous to clk.
- r  in  1  right-turn request, level.
- haz  in  1  hazard request, level.
- brake  in  1  brake pedal, level.
- LA, LB, LC  out  1 each  left lamps; LA innermost.
- RA, RB, RC  out  1 each  right lamps; RA innermost.
- busy  out  1  high whenever state ≠ IDLE.
- tick  out  1  one-cycle step strobe; debug/observation only.

## Operation
- Decoded requests are evaluated every cycle:
  - req_h = haz | (l & r)
  - req_l = l & ~r & ~haz
  - req_r = r & ~l & ~haz
- States: IDLE, L1, L2, L3, LOFF, R1, R2, R3, ROFF, H_ON, H_OFF.
- Decision rule D, evaluated in priority order:
  - req_h → H_ON
  - else req_l → L1
  - else req_r → R1
  - else IDLE
- IDLE: apply D on every clock with no tick wait. Entering any non-IDLE state from IDLE clears the prescaler.
- Left sweep: L1→L2→L3→LOFF, advancing on tick only. LOFF on tick: apply D.
- Right sweep: R1→R2→R3→ROFF, advancing on tick only. ROFF on tick: apply D.
- H_ON→H_OFF on tick. H_OFF on tick: apply D.
- Hazard preemption: req_h in any L*/R* state → H_ON on the next clock, prescaler cleared.
- Direction change: a change of direction, or a release of l/r, mid-sweep has no effect until the OFF step ends. A sweep always completes to OFF.
- Turning-side lamp patterns:

  | State | Turning side |
  |---|---|
  | L1 / R1 | A |
  | L2 / R2 | A B |
  | L3 / R3 | A B C |
  | LOFF / ROFF | none |

- Hazard patterns: H_ON lights all six lamps; H_OFF lights none.
- Brake:
  - IDLE with brake=1: all six lamps on.
  - During an L or R sweep: the non-turning side shows all three lamps on while brake=1, otherwise off.
  - In H_ON/H_OFF: brake is ignored.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps to 0.
  - tick=1 exactly when cnt==DIV-1.
  - cnt is also cleared in IDLE, so every step lasts exactly DIV cycles.
- Reset (rst=0 at an edge):
  - state=IDLE, cnt=0.
  - All lamps, busy and tick are 0 after that edge.
  - Reset overrides every other input, including mid-sweep.

## Timing
- All outputs are registered. Lamps are computed from next-state and brake, so lamp changes coincide with the state-change edge.
- Request latency: a request present before edge n shows its first lamp pattern after edge n (1 cycle).
- Step duration: DIV cycles per step. One full sweep is 4·DIV cycles; one hazard period is 2·DIV cycles.
- Brake latency: 1 cycle in every state.
- Request pulses shorter than one cycle are not supported. Inputs are already synchronised and debounced upstream.
- A tick and a req_h in the same cycle of a sweep: preemption wins, next state is H_ON.

## Structure
- Package tail_light_pkg holds:
  - the state enum (4-bit encoding);
  - 3-bit pattern constants PAT_OFF=000, PAT_1=001, PAT_2=011, PAT_3=111;
  - the lamp-ordering helper that reverses the bit order for the right side.
- Sub-module tick_prescaler:
  - parameter DIV;
  - inputs clk, rst, clr;
  - output tick.
- The FSM, arbitration and lamp registers stay in the top module.

## Test plan
All scenarios use DIV=4.
- Reset: rst=0 for 2 cycles with l=1 → all lamps 0, busy=0, tick=0; first sweep starts only after rst=1.
- Left held: l=1 from cycle 0 →
  - LA=1 after edge 1;
  - LA,LB after edge 5;
  - LA,LB,LC after edge 9;
  - left off after edge 13;
  - LA again after edge 17; right lamps stay 0 throughout.
- l=r=1 → all six on for 4 cycles, off for 4 cycles, repeating; busy=1.
- Preemption: right sweep in R2, haz pulsed high for 1 cycle → all six on at the next edge, then H_OFF, then D selects R1 if r is still held.
- Direction change: l→r switched during L2 → L3 and LOFF complete with full durations, then RA=1 with no gap beyond LOFF.
- Brake:
  - brake=1 in IDLE → all six on 1 cycle later;
  - brake=1 during a left sweep → RA,RB,RC=1 while the left side sequences;
  - rst=0 during L3 → all zero after the next edge.
